// File: rtl/settings_regfile.sv
// Byte-wide settings register file with a staging/live double buffer,
// a one-outstanding request/response port, commit and a sticky write lock.
module settings_regfile #(
    parameter int                    NumBytes   = 12,
    parameter int                    RoLastAddr = 5,
    parameter int                    AddrWidth  = 8,
    parameter logic [NumBytes*8-1:0] ResetValue = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [7:0]              req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [7:0]              rsp_rdata_o,
    output logic                    rsp_err_o,
    input  logic                    commit_i,
    input  logic                    lock_i,
    output logic [NumBytes*8-1:0]   settings_o,
    output logic                    dirty_o,
    output logic                    locked_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                state_r;
    logic                  ready_r;
    logic                  rsp_valid_r;
    logic [7:0]            rsp_rdata_r;
    logic                  rsp_err_r;
    logic                  dirty_r;
    logic                  locked_r;
    logic [NumBytes*8-1:0] staging_r;
    logic [NumBytes*8-1:0] live_r;

    logic [31:0]           addr_s;
    logic                  accept_s;
    logic                  in_range_s;
    logic                  wr_ok_s;
    logic [7:0]            rd_byte_s;

    // Request decode: acceptance, range check and write legality (old lock value)
    always_comb begin
        addr_s     = 32'(req_addr_i);
        accept_s   = req_valid_i & ready_r;
        in_range_s = (addr_s < 32'(NumBytes));
        wr_ok_s    = req_write_i & in_range_s & (addr_s > 32'(RoLastAddr)) & ~locked_r;
        if (in_range_s) begin
            rd_byte_s = staging_r[addr_s*32'd8 +: 8];
        end else begin
            rd_byte_s = 8'h00;
        end
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_RESP;
                        ready_r     <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= req_write_i ? 8'h00 : rd_byte_s;
                        rsp_err_r   <= req_write_i ? ~wr_ok_s : ~in_range_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        ready_r     <= 1'b1;
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_r     <= ST_IDLE;
                        ready_r     <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 8'h00;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 8'h00;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Staging/live arrays; live samples pre-write staging when commit and write coincide
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            staging_r <= ResetValue;
            live_r    <= ResetValue;
            dirty_r   <= 1'b0;
        end else begin
            if (commit_i) begin
                live_r <= staging_r;
            end
            if (accept_s && wr_ok_s) begin
                staging_r[addr_s*32'd8 +: 8] <= req_wdata_i;
                dirty_r                      <= 1'b1;
            end else if (commit_i) begin
                dirty_r <= 1'b0;
            end else begin
                dirty_r <= dirty_r;
            end
        end
    end

    // Sticky lock, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_r <= 1'b0;
        end else if (lock_i) begin
            locked_r <= 1'b1;
        end else begin
            locked_r <= locked_r;
        end
    end

    assign req_ready_o = ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign settings_o  = live_r;
    assign dirty_o     = dirty_r;
    assign locked_o    = locked_r;

endmodule
